migration_ring_node: RTL and testbench
======================================

Name: migration_ring_node

Overview:
- Ring stop between neighbouring cell position-update stages.
- Accepts migrating particle packets (position, velocity, destination cell) from this cell's position updater and from the previous ring node.
- Delivers packets addressed to this cell to the local updater's node inputs.
- Forwards all other packets to the next node, with FIFO buffering, back-pressure and a quiescence flag used for update-phase completion.

Parameters:
- DEPTH, 8, entries in each of the forward FIFO and the delivery FIFO (power of 2, at least 4).
- NCELLS, 27, number of valid cell indices (UNIVERSE^3).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- my_cell  in  33  this node's cell index; static during operation.
- local_p_in  in  97  position packet from local updater; bit 96 = 1 means null.
- local_v_in  in  97  velocity from local updater; bit 96 = 1 means null.
- local_c_in  in  33  destination cell from local updater; bit 32 = 1 means null.
- local_stall  out  1  local packet skid occupied; updater must not present a new packet.
- ring_p_in  in  97  packet position from the previous node.
- ring_v_in  in  97  packet velocity from the previous node.
- ring_c_in  in  33  packet destination cell from the previous node.
- ring_stall_out  out  1  back-pressure to the previous node.
- ring_p_out  out  97  packet position to the next node.
- ring_v_out  out  97  packet velocity to the next node.
- ring_c_out  out  33  packet destination cell to the next node.
- ring_stall_in  in  1  next node cannot accept.
- deliver_p  out  97  packet position for this cell, to the local updater.
- deliver_v  out  97  packet velocity for this cell, to the local updater.
- deliver_c  out  33  packet destination cell for this cell, to the local updater.
- deliver_ack  in  1  local updater consumed deliver_*.
- ring_empty  out  1  node holds nothing and sees no valid input.
- err  out  1  sticky error.

Behaviour:
- Packet validity:
  - A packet is valid only when p[96]=0, v[96]=0 and c[32]=0.
  - If any of those bits is 1, the whole packet is null.
  - Every null output drives {1'b1, zeros} on all three fields.
- Reset (async):
  - Both FIFOs and the skid are emptied.
  - ring_*_out and deliver_* are null.
  - local_stall=0, ring_stall_out=0, ring_empty=1, err=0.
  - rst mid-operation discards all buffered packets with no output glitch other than going null.
- Ring input classification (each posedge):
  - A valid ring packet with c >= NCELLS is dropped and sets err.
  - If c == my_cell, the packet is pushed to the delivery FIFO.
  - Otherwise it is pushed to the forward FIFO.
- Local input:
  - A valid local packet is latched into the 1-entry skid.
  - A valid local packet arriving while the skid is full is lost and sets err.
  - local_stall = skid occupied (registered).
- Forward FIFO write port (one push per cycle, priority order):
  1. Ring forward packet.
  2. Skid contents.
  - The skid drains in the first cycle with no ring forward push and FIFO not full.
  - A local packet with c == my_cell is pushed like any other (loops the ring once). No shortcut.
- Ring output register:
  - On a posedge with ring_stall_in=0, it loads the forward FIFO head (pop), else null.
  - With ring_stall_in=1 it holds its value.
  - First-word bypass: a packet arriving into an empty forward FIFO appears on ring_*_out at the next posedge (latency 1).
- Delivery register:
  - Loads the delivery FIFO head when it is currently null, or when deliver_ack=1 at that edge. Otherwise it holds.
  - Latency 1 with bypass.
  - deliver_ack while deliver_* is null is ignored.
- Back-pressure:
  - ring_stall_out is registered: 1 when forward count >= DEPTH-2 or delivery count >= DEPTH-2.
  - This tolerates 2 in-flight arrivals.
  - A push into a full FIFO sets err, and the packet is dropped.
- Ordering: FIFO order is preserved per path. No reordering between ring-origin packets.
- Counters: forward and delivery counts are log2(DEPTH)+1 bits, with wrapping pointers. Simultaneous push and pop leaves the count unchanged.
- ring_empty: combinational. 1 iff all of the following:
  - both FIFOs are empty,
  - the skid is empty,
  - ring_*_out and deliver_* are null,
  - the ring and local inputs are null.
- err: cleared only by rst.

Test Plan:
- Reset with garbage on the inputs -> all data outputs {1,0...}, stalls 0, ring_empty=1, err=0.
- my_cell=5, ring packet c=5, p=0x000A_000B_000C for 1 cycle -> deliver_* valid at next posedge and held while deliver_ack=0; ring_*_out stays null; one cycle after deliver_ack, deliver_* goes null.
- my_cell=5, ring packet c=7 -> ring_c_out=7 at next posedge; deliver_* stays null.
- Same-cycle local c=9 and ring c=7 -> ring_c_out=7 then 9 on consecutive cycles; local_stall=1 for exactly one cycle.
- ring_stall_in=1 with 8 back-to-back forwards (DEPTH=8) -> ring_stall_out=1 the cycle after the count reaches 6; stop feeding then; release ring_stall_in -> in-order drain, no loss, err=0.
- Ring packet c=27 (NCELLS=27) -> dropped, err=1 sticky; assert rst while 3 packets are buffered -> all outputs null, ring_empty=1, err=0.

Source files
------------

// File: rtl/migration_ring_node.sv
// Ring stop for particle migration: classifies ring/local packets, buffers
// forwarded and delivered packets in two FIFOs, and reports quiescence.
module migration_ring_node #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NCELLS = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [32:0] my_cell,
  input  logic [96:0] local_p_in,
  input  logic [96:0] local_v_in,
  input  logic [32:0] local_c_in,
  output logic        local_stall,
  input  logic [96:0] ring_p_in,
  input  logic [96:0] ring_v_in,
  input  logic [32:0] ring_c_in,
  output logic        ring_stall_out,
  output logic [96:0] ring_p_out,
  output logic [96:0] ring_v_out,
  output logic [32:0] ring_c_out,
  input  logic        ring_stall_in,
  output logic [96:0] deliver_p,
  output logic [96:0] deliver_v,
  output logic [32:0] deliver_c,
  input  logic        deliver_ack,
  output logic        ring_empty,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 224;

  logic          ring_valid, ring_bad, ring_dlv, ring_fwd, local_valid;
  logic [DW-1:0] ring_data, local_data;

  assign ring_valid  = !ring_p_in[96] && !ring_v_in[96] && !ring_c_in[32];
  assign local_valid = !local_p_in[96] && !local_v_in[96] && !local_c_in[32];
  assign ring_bad    = ring_valid && (ring_c_in[31:0] >= 32'(NCELLS));
  assign ring_dlv    = ring_valid && !ring_bad && (ring_c_in == my_cell);
  assign ring_fwd    = ring_valid && !ring_bad && (ring_c_in != my_cell);
  assign ring_data   = {ring_p_in[95:0], ring_v_in[95:0], ring_c_in[31:0]};
  assign local_data  = {local_p_in[95:0], local_v_in[95:0], local_c_in[31:0]};

  logic          skid_vld;
  logic [DW-1:0] skid_dat;

  logic [DW-1:0] fwd_mem [DEPTH];
  logic [AW-1:0] fwd_rptr, fwd_wptr;
  logic [CW-1:0] fwd_cnt;
  logic          fwd_pop, fwd_room, fwd_push_req, fwd_bypass, fwd_wr, fwd_ovf, skid_drain;
  logic [DW-1:0] fwd_push_data;

  logic [DW-1:0] dlv_mem [DEPTH];
  logic [AW-1:0] dlv_rptr, dlv_wptr;
  logic [CW-1:0] dlv_cnt;
  logic          dlv_load, dlv_pop, dlv_room, dlv_bypass, dlv_wr, dlv_ovf;

  logic          ring_vld_q, dlv_vld_q;
  logic [DW-1:0] ring_dat_q, dlv_dat_q;

  // Forward path: ring packets take the write port ahead of the skid.
  assign fwd_pop       = !ring_stall_in && (fwd_cnt != '0);
  assign fwd_room      = (fwd_cnt != CW'(DEPTH)) || fwd_pop;
  assign skid_drain    = skid_vld && !ring_fwd && fwd_room;
  assign fwd_push_req  = ring_fwd || skid_drain;
  assign fwd_push_data = ring_fwd ? ring_data : skid_dat;
  assign fwd_bypass    = !ring_stall_in && (fwd_cnt == '0) && fwd_push_req;
  assign fwd_wr        = fwd_push_req && !fwd_bypass && fwd_room;
  assign fwd_ovf       = ring_fwd && !fwd_room;

  // Delivery path: the output register refills when empty or acknowledged.
  assign dlv_load   = !dlv_vld_q || deliver_ack;
  assign dlv_pop    = dlv_load && (dlv_cnt != '0);
  assign dlv_room   = (dlv_cnt != CW'(DEPTH)) || dlv_pop;
  assign dlv_bypass = dlv_load && (dlv_cnt == '0) && ring_dlv;
  assign dlv_wr     = ring_dlv && !dlv_bypass && dlv_room;
  assign dlv_ovf    = ring_dlv && !dlv_room;

  always_ff @(posedge clk) begin
    if (fwd_wr) fwd_mem[fwd_wptr] <= fwd_push_data;
    if (dlv_wr) dlv_mem[dlv_wptr] <= ring_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_rptr       <= '0;
      fwd_wptr       <= '0;
      fwd_cnt        <= '0;
      dlv_rptr       <= '0;
      dlv_wptr       <= '0;
      dlv_cnt        <= '0;
      skid_vld       <= 1'b0;
      skid_dat       <= '0;
      ring_vld_q     <= 1'b0;
      ring_dat_q     <= '0;
      dlv_vld_q      <= 1'b0;
      dlv_dat_q      <= '0;
      ring_stall_out <= 1'b0;
      err            <= 1'b0;
    end else begin
      if (fwd_wr)  fwd_wptr <= fwd_wptr + AW'(1);
      if (fwd_pop) fwd_rptr <= fwd_rptr + AW'(1);
      if (fwd_wr && !fwd_pop)      fwd_cnt <= fwd_cnt + CW'(1);
      else if (!fwd_wr && fwd_pop) fwd_cnt <= fwd_cnt - CW'(1);

      if (dlv_wr)  dlv_wptr <= dlv_wptr + AW'(1);
      if (dlv_pop) dlv_rptr <= dlv_rptr + AW'(1);
      if (dlv_wr && !dlv_pop)      dlv_cnt <= dlv_cnt + CW'(1);
      else if (!dlv_wr && dlv_pop) dlv_cnt <= dlv_cnt - CW'(1);

      // A local packet is only accepted into an empty skid.
      if (!skid_vld && local_valid) begin
        skid_vld <= 1'b1;
        skid_dat <= local_data;
      end else if (skid_drain) begin
        skid_vld <= 1'b0;
        skid_dat <= '0;
      end

      if (!ring_stall_in) begin
        if (fwd_cnt != '0) begin
          ring_vld_q <= 1'b1;
          ring_dat_q <= fwd_mem[fwd_rptr];
        end else if (fwd_push_req) begin
          ring_vld_q <= 1'b1;
          ring_dat_q <= fwd_push_data;
        end else begin
          ring_vld_q <= 1'b0;
          ring_dat_q <= '0;
        end
      end

      if (dlv_load) begin
        if (dlv_cnt != '0) begin
          dlv_vld_q <= 1'b1;
          dlv_dat_q <= dlv_mem[dlv_rptr];
        end else if (ring_dlv) begin
          dlv_vld_q <= 1'b1;
          dlv_dat_q <= ring_data;
        end else begin
          dlv_vld_q <= 1'b0;
          dlv_dat_q <= '0;
        end
      end

      ring_stall_out <= (fwd_cnt >= CW'(DEPTH - 2)) || (dlv_cnt >= CW'(DEPTH - 2));

      if (ring_bad || fwd_ovf || dlv_ovf || (local_valid && skid_vld)) err <= 1'b1;
    end
  end

  assign local_stall = skid_vld;

  // Null registers hold zero data, so the null bit is the only thing to add.
  assign ring_p_out = {!ring_vld_q, ring_dat_q[223:128]};
  assign ring_v_out = {!ring_vld_q, ring_dat_q[127:32]};
  assign ring_c_out = {!ring_vld_q, ring_dat_q[31:0]};
  assign deliver_p  = {!dlv_vld_q, dlv_dat_q[223:128]};
  assign deliver_v  = {!dlv_vld_q, dlv_dat_q[127:32]};
  assign deliver_c  = {!dlv_vld_q, dlv_dat_q[31:0]};

  assign ring_empty = (fwd_cnt == '0) && (dlv_cnt == '0) && !skid_vld &&
                      !ring_vld_q && !dlv_vld_q && !ring_valid && !local_valid;

endmodule

// File: tb/tb_migration_ring_node.sv
// Directed bench for migration_ring_node: delivery, forwarding, skid,
// back-pressure, bad-cell error and mid-run reset.
module tb_migration_ring_node;

  logic        clk = 1'b0;
  logic        rst;
  logic [32:0] my_cell;
  logic [96:0] local_p_in, local_v_in;
  logic [32:0] local_c_in;
  logic        local_stall;
  logic [96:0] ring_p_in, ring_v_in;
  logic [32:0] ring_c_in;
  logic        ring_stall_out;
  logic [96:0] ring_p_out, ring_v_out;
  logic [32:0] ring_c_out;
  logic        ring_stall_in;
  logic [96:0] deliver_p, deliver_v;
  logic [32:0] deliver_c;
  logic        deliver_ack;
  logic        ring_empty;
  logic        err;

  int checks = 0;
  int errors = 0;

  localparam logic [96:0] NULL97 = {1'b1, 96'd0};
  localparam logic [32:0] NULL33 = {1'b1, 32'd0};

  migration_ring_node #(.DEPTH(8), .NCELLS(27)) dut (
    .clk(clk), .rst(rst), .my_cell(my_cell),
    .local_p_in(local_p_in), .local_v_in(local_v_in), .local_c_in(local_c_in),
    .local_stall(local_stall),
    .ring_p_in(ring_p_in), .ring_v_in(ring_v_in), .ring_c_in(ring_c_in),
    .ring_stall_out(ring_stall_out),
    .ring_p_out(ring_p_out), .ring_v_out(ring_v_out), .ring_c_out(ring_c_out),
    .ring_stall_in(ring_stall_in),
    .deliver_p(deliver_p), .deliver_v(deliver_v), .deliver_c(deliver_c),
    .deliver_ack(deliver_ack), .ring_empty(ring_empty), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [96:0] vp(input logic [95:0] x);
    return {1'b0, x};
  endfunction

  function automatic logic [32:0] vc(input int c);
    return {1'b0, 32'(c)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ring(input logic vld, input int c, input logic [95:0] p);
    if (vld) begin
      ring_p_in = {1'b0, p};
      ring_v_in = {1'b0, p + 96'd1};
      ring_c_in = {1'b0, 32'(c)};
    end else begin
      ring_p_in = NULL97;
      ring_v_in = NULL97;
      ring_c_in = NULL33;
    end
  endtask

  task automatic drive_local(input logic vld, input int c, input logic [95:0] p);
    if (vld) begin
      local_p_in = {1'b0, p};
      local_v_in = {1'b0, p + 96'd1};
      local_c_in = {1'b0, 32'(c)};
    end else begin
      local_p_in = NULL97;
      local_v_in = NULL97;
      local_c_in = NULL33;
    end
  endtask

  initial begin
    // Reset with null-flagged garbage on every input.
    rst           = 1'b1;
    my_cell       = vc(5);
    ring_p_in     = {1'b1, 96'hDEAD_BEEF_0123};
    ring_v_in     = {1'b1, 96'h55AA};
    ring_c_in     = {1'b1, 32'h1234};
    local_p_in    = {1'b1, 96'hCAFE};
    local_v_in    = {1'b1, 96'h77};
    local_c_in    = {1'b1, 32'h9};
    ring_stall_in = 1'b1;
    deliver_ack   = 1'b1;
    #1;
    chk("rst_ring_p", 128'(ring_p_out), 128'(NULL97));
    chk("rst_ring_c", 128'(ring_c_out), 128'(NULL33));
    chk("rst_dlv_p", 128'(deliver_p), 128'(NULL97));
    chk("rst_dlv_c", 128'(deliver_c), 128'(NULL33));
    chk("rst_lstall", 128'(local_stall), 128'(0));
    chk("rst_rstall", 128'(ring_stall_out), 128'(0));
    chk("rst_empty", 128'(ring_empty), 128'(1));
    chk("rst_err", 128'(err), 128'(0));
    step();
    step();
    rst           = 1'b0;
    ring_stall_in = 1'b0;
    deliver_ack   = 1'b0;
    drive_ring(1'b0, 0, 96'd0);
    drive_local(1'b0, 0, 96'd0);
    step();

    // Delivery to this cell, held until acknowledged.
    drive_ring(1'b1, 5, 96'h000A_000B_000C);
    step();
    chk("dlv_p", 128'(deliver_p), 128'(vp(96'h000A_000B_000C)));
    chk("dlv_v", 128'(deliver_v), 128'(vp(96'h000A_000B_000D)));
    chk("dlv_c", 128'(deliver_c), 128'(vc(5)));
    chk("dlv_ring_null", 128'(ring_c_out), 128'(NULL33));
    drive_ring(1'b0, 0, 96'd0);
    step();
    step();
    chk("dlv_hold", 128'(deliver_c), 128'(vc(5)));
    chk("dlv_hold_ring_null", 128'(ring_p_out), 128'(NULL97));
    deliver_ack = 1'b1;
    step();
    deliver_ack = 1'b0;
    chk("dlv_after_ack", 128'(deliver_p), 128'(NULL97));
    chk("idle_empty", 128'(ring_empty), 128'(1));

    // Forward to another cell.
    drive_ring(1'b1, 7, 96'h77);
    step();
    chk("fwd_c", 128'(ring_c_out), 128'(vc(7)));
    chk("fwd_p", 128'(ring_p_out), 128'(vp(96'h77)));
    chk("fwd_dlv_null", 128'(deliver_c), 128'(NULL33));
    drive_ring(1'b0, 0, 96'd0);
    step();
    chk("fwd_gone", 128'(ring_c_out), 128'(NULL33));

    // Local and ring in the same cycle: ring first, skid next cycle.
    drive_ring(1'b1, 7, 96'h71);
    drive_local(1'b1, 9, 96'h99);
    step();
    chk("mix_first", 128'(ring_c_out), 128'(vc(7)));
    chk("mix_lstall1", 128'(local_stall), 128'(1));
    drive_ring(1'b0, 0, 96'd0);
    drive_local(1'b0, 0, 96'd0);
    step();
    chk("mix_second", 128'(ring_c_out), 128'(vc(9)));
    chk("mix_second_p", 128'(ring_p_out), 128'(vp(96'h99)));
    chk("mix_lstall0", 128'(local_stall), 128'(0));
    step();
    chk("mix_done", 128'(ring_c_out), 128'(NULL33));

    // Two queued deliveries keep their order across acks.
    drive_ring(1'b1, 5, 96'h1);
    step();
    drive_ring(1'b1, 5, 96'h2);
    step();
    drive_ring(1'b0, 0, 96'd0);
    chk("dq_first", 128'(deliver_p), 128'(vp(96'h1)));
    deliver_ack = 1'b1;
    step();
    deliver_ack = 1'b0;
    chk("dq_second", 128'(deliver_p), 128'(vp(96'h2)));
    step();
    chk("dq_second_hold", 128'(deliver_p), 128'(vp(96'h2)));
    deliver_ack = 1'b1;
    step();
    deliver_ack = 1'b0;
    chk("dq_drained", 128'(deliver_c), 128'(NULL33));

    // Back-pressure: fill the forward FIFO while the next node stalls.
    ring_stall_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_ring(1'b1, 10 + i, 96'(256 + i));
      step();
      chk($sformatf("bp_stall_%0d", i), 128'(ring_stall_out), 128'(i >= 6));
      chk($sformatf("bp_out_null_%0d", i), 128'(ring_c_out), 128'(NULL33));
    end
    drive_ring(1'b0, 0, 96'd0);
    ring_stall_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("bp_drain_c_%0d", i), 128'(ring_c_out), 128'(vc(10 + i)));
      chk($sformatf("bp_drain_p_%0d", i), 128'(ring_p_out), 128'(vp(96'(256 + i))));
    end
    step();
    chk("bp_tail_null", 128'(ring_c_out), 128'(NULL33));
    chk("bp_stall_clear", 128'(ring_stall_out), 128'(0));
    chk("bp_empty", 128'(ring_empty), 128'(1));
    chk("bp_no_err", 128'(err), 128'(0));

    // Out-of-range cell is dropped and latches err.
    drive_ring(1'b1, 27, 96'hBAD);
    step();
    drive_ring(1'b0, 0, 96'd0);
    chk("bad_err", 128'(err), 128'(1));
    chk("bad_ring_null", 128'(ring_c_out), 128'(NULL33));
    chk("bad_dlv_null", 128'(deliver_c), 128'(NULL33));
    step();
    chk("bad_err_sticky", 128'(err), 128'(1));

    // Buffer packets, then reset mid-operation.
    ring_stall_in = 1'b1;
    drive_ring(1'b1, 20, 96'h20);
    step();
    drive_ring(1'b1, 21, 96'h21);
    step();
    drive_ring(1'b1, 5, 96'h55);
    drive_local(1'b1, 9, 96'h9);
    step();
    drive_ring(1'b0, 0, 96'd0);
    drive_local(1'b0, 0, 96'd0);
    chk("pre_rst_dlv", 128'(deliver_c), 128'(vc(5)));
    chk("pre_rst_lstall", 128'(local_stall), 128'(1));
    chk("pre_rst_empty", 128'(ring_empty), 128'(0));
    rst = 1'b1;
    #1;
    chk("mid_rst_dlv", 128'(deliver_p), 128'(NULL97));
    chk("mid_rst_ring", 128'(ring_p_out), 128'(NULL97));
    chk("mid_rst_lstall", 128'(local_stall), 128'(0));
    chk("mid_rst_empty", 128'(ring_empty), 128'(1));
    chk("mid_rst_err", 128'(err), 128'(0));
    step();
    rst           = 1'b0;
    ring_stall_in = 1'b0;
    step();
    step();
    chk("post_rst_ring", 128'(ring_c_out), 128'(NULL33));
    chk("post_rst_dlv", 128'(deliver_c), 128'(NULL33));
    chk("post_rst_empty", 128'(ring_empty), 128'(1));
    chk("post_rst_err", 128'(err), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
